// File: rtl/ym3438_bus_master_if.sv
// Request and chip-bus signals between the YM3438 bus master and its
// surroundings.
interface ym3438_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_bank;
    logic [7:0] req_reg;
    logic [7:0] req_data;
    logic       CS;
    logic       WR;
    logic       RD;
    logic [1:0] address;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;
    logic       done;
    logic       timeout;

    modport master (
        input  req_valid, req_bank, req_reg, req_data, data_i,
        output req_ready, CS, WR, RD, address, data_o, data_oe, done, timeout
    );

    modport slave (
        output req_valid, req_bank, req_reg, req_data, data_i,
        input  req_ready, CS, WR, RD, address, data_o, data_oe, done, timeout
    );
endinterface

// File: rtl/ym3438_bus_master.sv
// YM3438 register-write bus master: address phase (skipped on a cache hit),
// data phase, then busy polling until clear or timeout. All outputs registered.
module ym3438_bus_master #(
    parameter int unsigned T_SU     = 1,
    parameter int unsigned T_WR     = 4,
    parameter int unsigned T_GAP    = 2,
    parameter int unsigned T_RD     = 3,
    parameter int unsigned POLL_MAX = 255
) (
    input logic                 MCLK,
    input logic                 IC,
    ym3438_bus_master_if.master bus
);
    // Zero-length phases are stretched to one cycle.
    localparam int unsigned TSu     = (T_SU == 0) ? 1 : T_SU;
    localparam int unsigned TWr     = (T_WR == 0) ? 1 : T_WR;
    localparam int unsigned TGap    = (T_GAP == 0) ? 1 : T_GAP;
    localparam int unsigned TRd     = (T_RD == 0) ? 1 : T_RD;
    localparam int unsigned TMaxA   = (TSu > TWr) ? TSu : TWr;
    localparam int unsigned TMaxB   = (TGap > TRd) ? TGap : TRd;
    localparam int unsigned TMax    = (TMaxA > TMaxB) ? TMaxA : TMaxB;
    localparam int unsigned CntW    = (TMax > 1) ? $clog2(TMax) : 1;
    localparam int unsigned PollMax = (POLL_MAX == 0) ? 1 : POLL_MAX;
    localparam int unsigned PollW   = $clog2(PollMax + 1);

    typedef enum logic [3:0] {
        StIdle, StASu, StAWr, StAGap, StDSu, StDWr, StDGap, StPRd, StPGap
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PollW-1:0]   poll_q, poll_d;
    logic               busy_q, busy_d;
    logic               bank_q, bank_d;
    logic [7:0]         regnum_q, regnum_d;
    logic [7:0]         data_q, data_d;
    logic               cache_valid_q, cache_valid_d;
    logic [8:0]         cache_q, cache_d;
    logic               ready_q, ready_d;
    logic               cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic [1:0]         addr_q, addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               phase_end;

    // Counter reload value (length - 1) for the phase being entered.
    function automatic logic [CntW-1:0] phase_len(state_e s);
        case (s)
            StASu, StDSu:   return CntW'(TSu - 1);
            StAWr, StDWr:   return CntW'(TWr - 1);
            StAGap, StDGap: return CntW'(TGap - 1);
            StPRd:          return CntW'(TRd - 1);
            default:        return '0;
        endcase
    endfunction

    assign phase_end = (cnt_q == '0);

    // Next state, request latch, address cache and poll bookkeeping.
    always_comb begin
        state_d       = state_q;
        poll_d        = poll_q;
        busy_d        = busy_q;
        bank_d        = bank_q;
        regnum_d      = regnum_q;
        data_d        = data_q;
        cache_valid_d = cache_valid_q;
        cache_d       = cache_q;
        done_d        = 1'b0;
        tmo_d         = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req_valid && ready_q) begin
                    bank_d   = bus.req_bank;
                    regnum_d = bus.req_reg;
                    data_d   = bus.req_data;
                    state_d  = (cache_valid_q && cache_q == {bus.req_bank, bus.req_reg})
                               ? StDSu : StASu;
                end
            end
            StASu:  if (phase_end) state_d = StAWr;
            StAWr:  if (phase_end) state_d = StAGap;
            StAGap: if (phase_end) state_d = StDSu;
            StDSu:  if (phase_end) state_d = StDWr;
            StDWr:  if (phase_end) state_d = StDGap;
            StDGap: begin
                if (phase_end) begin
                    cache_d       = {bank_q, regnum_q};
                    cache_valid_d = 1'b1;
                    poll_d        = '0;
                    state_d       = StPRd;
                end
            end
            StPRd: begin
                if (phase_end) begin
                    busy_d  = bus.data_i[7];
                    state_d = StPGap;
                end
            end
            StPGap: begin
                if (!busy_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    poll_d = poll_q + 1'b1;
                    if (poll_d == PollW'(PollMax)) begin
                        tmo_d         = 1'b1;
                        cache_valid_d = 1'b0;
                        state_d       = StIdle;
                    end else begin
                        state_d = StPRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = phase_len(state_d);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Bus outputs decoded from the next state so they register in step with it.
    always_comb begin
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = addr_q;
        dout_d = dout_q;
        oe_d   = 1'b0;
        // Ready stays low in the pulse cycle so done/timeout never coincide with its rise.
        ready_d = (state_d == StIdle) && !done_d && !tmo_d;
        case (state_d)
            StASu, StAWr: begin
                cs_d   = 1'b0;
                wr_d   = (state_d != StAWr);
                addr_d = {bank_d, 1'b0};
                dout_d = regnum_d;
                oe_d   = 1'b1;
            end
            StDSu, StDWr: begin
                cs_d   = 1'b0;
                wr_d   = (state_d != StDWr);
                addr_d = {bank_d, 1'b1};
                dout_d = data_d;
                oe_d   = 1'b1;
            end
            StAGap, StDGap: oe_d = 1'b1;
            StPRd: begin
                cs_d   = 1'b0;
                rd_d   = 1'b0;
                addr_d = 2'b00;
            end
            default: ;
        endcase
    end

    // State and output registers; IC drops every strobe immediately.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            poll_q        <= '0;
            busy_q        <= 1'b0;
            bank_q        <= 1'b0;
            regnum_q      <= '0;
            data_q        <= '0;
            cache_valid_q <= 1'b0;
            cache_q       <= '0;
            ready_q       <= 1'b0;
            cs_q          <= 1'b1;
            wr_q          <= 1'b1;
            rd_q          <= 1'b1;
            addr_q        <= '0;
            dout_q        <= '0;
            oe_q          <= 1'b0;
            done_q        <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            poll_q        <= poll_d;
            busy_q        <= busy_d;
            bank_q        <= bank_d;
            regnum_q      <= regnum_d;
            data_q        <= data_d;
            cache_valid_q <= cache_valid_d;
            cache_q       <= cache_d;
            ready_q       <= ready_d;
            cs_q          <= cs_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            oe_q          <= oe_d;
            done_q        <= done_d;
            tmo_q         <= tmo_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.CS        = cs_q;
    assign bus.WR        = wr_q;
    assign bus.RD        = rd_q;
    assign bus.address   = addr_q;
    assign bus.data_o    = dout_q;
    assign bus.data_oe   = oe_q;
    assign bus.done      = done_q;
    assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_ym3438_bus_master.sv
// Bench for ym3438_bus_master: directed and random register writes, each
// captured cycle by cycle and compared with a transaction-level model.
module tb_ym3438_bus_master;
    localparam int unsigned TSu     = 1;
    localparam int unsigned TWr     = 4;
    localparam int unsigned TGap    = 2;
    localparam int unsigned TRd     = 3;
    localparam int unsigned PollMax = 4;

    logic MCLK = 1'b0;
    logic IC   = 1'b0;

    ym3438_bus_master_if bus ();

    ym3438_bus_master #(
        .T_SU    (TSu),
        .T_WR    (TWr),
        .T_GAP   (TGap),
        .T_RD    (TRd),
        .POLL_MAX(PollMax)
    ) dut (
        .MCLK(MCLK),
        .IC  (IC),
        .bus (bus)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic       cs, wr, rd;
        logic [1:0] addr;
        logic [7:0] dout;
        logic       oe, done, tmo, rdy;
    } snap_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t trace[$];
    snap_t post;
    bit    cache_valid = 1'b0;
    logic [8:0] cache_key = '0;
    logic [7:0] regs_pool[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic snap_t sample();
        snap_t s;
        s.cs   = bus.CS;
        s.wr   = bus.WR;
        s.rd   = bus.RD;
        s.addr = bus.address;
        s.dout = bus.data_o;
        s.oe   = bus.data_oe;
        s.done = bus.done;
        s.tmo  = bus.timeout;
        s.rdy  = bus.req_ready;
        return s;
    endfunction

    // One register write; expectations come from the cache/poll model only.
    task automatic write(input string tag, input bit bank, input logic [7:0] rg,
                         input logic [7:0] dt, input int busy_n, output int lat);
        bit         hit;
        bit         exp_tmo;
        int         polls, nw, exp_lat, w, completed, n, i, j, k, g, wl, rl;
        int         wr_runs, rd_runs, bad_w, bad_r, bad_gap, illegal, ended;
        logic [1:0] exp_a;
        logic [7:0] exp_d;
        snap_t      s, prev;

        hit     = cache_valid && cache_key == {bank, rg};
        exp_tmo = (busy_n >= PollMax);
        polls   = exp_tmo ? PollMax : busy_n + 1;
        nw      = hit ? 1 : 2;
        exp_lat = nw * (TSu + TWr + TGap) + polls * (TRd + 1);

        w = 0;
        while (bus.req_ready !== 1'b1 && w < 100) begin
            @(negedge MCLK);
            w++;
        end
        chk({tag, "_ready_wait"}, 32'(bus.req_ready), 1);

        bus.req_valid = 1'b1;
        bus.req_bank  = bank;
        bus.req_reg   = rg;
        bus.req_data  = dt;
        completed     = 0;
        bus.data_i    = {(busy_n > 0), 7'($urandom)};
        prev          = sample();
        trace.delete();
        ended = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge MCLK);
            s = sample();
            trace.push_back(s);
            // Keep valid up with junk fields: must be ignored until back in idle.
            bus.req_bank = 1'($urandom);
            bus.req_reg  = 8'($urandom);
            bus.req_data = 8'($urandom);
            if (prev.rd == 1'b0 && s.rd == 1'b1) completed++;
            prev       = s;
            bus.data_i = {(completed < busy_n), 7'($urandom)};
            if (s.done || s.tmo) begin
                ended = 1;
                break;
            end
        end
        bus.req_valid = 1'b0;
        chk({tag, "_ended"}, 32'(ended), 1);
        @(negedge MCLK);
        post = sample();

        n = trace.size();
        lat = n - 1;
        wr_runs = 0; rd_runs = 0; bad_w = 0; bad_r = 0; bad_gap = 0; illegal = 0;
        for (int m = 0; m < n; m++) begin
            if ((!trace[m].wr && !trace[m].rd) || (trace[m].cs && (!trace[m].wr || !trace[m].rd))
                || (trace[m].done && trace[m].tmo))
                illegal++;
        end
        i = 0;
        while (i < n) begin
            if (trace[i].cs) begin
                i++;
                continue;
            end
            j = i; wl = 0; rl = 0;
            while (j < n && !trace[j].cs) begin
                if (!trace[j].wr) wl++;
                if (!trace[j].rd) rl++;
                if (trace[j].addr != trace[i].addr) bad_w++;
                j++;
            end
            g = 0; k = j;
            while (k < n && trace[k].cs) begin
                if (rl == 0 && !trace[k].oe) bad_gap++;
                g++;
                k++;
            end
            if (rl == 0) begin
                exp_a = (hit || wr_runs == 1) ? {bank, 1'b1} : {bank, 1'b0};
                exp_d = (hit || wr_runs == 1) ? dt : rg;
                if (wr_runs >= nw || rd_runs > 0) bad_w++;
                if (trace[i].addr != exp_a || (j - i) != int'(TSu + TWr) || wl != int'(TWr))
                    bad_w++;
                if (!trace[i].wr == 1'b1 || trace[j-1].wr != 1'b0) bad_w++;
                for (int m = i; m < j; m++)
                    if (trace[m].dout != exp_d || !trace[m].oe) bad_w++;
                if (g != int'(TGap)) bad_gap++;
                wr_runs++;
            end else begin
                if (wr_runs != nw || (j - i) != int'(TRd) || rl != (j - i) || trace[i].addr != 0)
                    bad_r++;
                for (int m = i; m < j; m++)
                    if (trace[m].oe) bad_r++;
                if (k < n && g != 1) bad_gap++;
                rd_runs++;
            end
            i = k;
        end

        chk({tag, "_write_strobes"}, 32'(wr_runs), 32'(nw));
        chk({tag, "_read_polls"}, 32'(rd_runs), 32'(polls));
        chk({tag, "_write_shape"}, 32'(bad_w), 0);
        chk({tag, "_read_shape"}, 32'(bad_r), 0);
        chk({tag, "_gaps"}, 32'(bad_gap), 0);
        chk({tag, "_bus_legal"}, 32'(illegal), 0);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_done"}, 32'(trace[n-1].done), 32'(!exp_tmo));
        chk({tag, "_timeout"}, 32'(trace[n-1].tmo), 32'(exp_tmo));
        chk({tag, "_ready_in_pulse"}, 32'(trace[n-1].rdy), 0);
        chk({tag, "_ready_after"}, 32'(post.rdy), 1);
        chk({tag, "_pulse_single"}, 32'({post.done, post.tmo}), 0);

        cache_valid = !exp_tmo;
        cache_key   = {bank, rg};
    endtask

    initial begin
        int lat, lat1, lat2, found, saw_done;
        snap_t s;

        regs_pool[0] = 8'h28;
        regs_pool[1] = 8'hA4;
        regs_pool[2] = 8'h40;
        regs_pool[3] = 8'hB0;
        bus.req_valid = 1'b0;
        bus.req_bank  = 1'b0;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        bus.data_i    = '0;
        IC = 1'b0;

        repeat (3) @(negedge MCLK);
        s = sample();
        chk("reset_strobes", 32'({s.cs, s.wr, s.rd}), 32'b111);
        chk("reset_address", 32'(s.addr), 0);
        chk("reset_data", 32'(s.dout), 0);
        chk("reset_oe", 32'(s.oe), 0);
        chk("reset_pulses", 32'({s.done, s.tmo}), 0);
        IC = 1'b1;
        @(negedge MCLK);
        chk("ready_after_reset", 32'(bus.req_ready), 1);

        write("basic", 1'b0, 8'h28, 8'hF0, 0, lat);

        write("a4_first", 1'b1, 8'hA4, 8'($urandom), 0, lat1);
        write("a4_second", 1'b1, 8'hA4, 8'($urandom), 0, lat2);
        chk("a4_saving", 32'(lat1 - lat2), 32'(TSu + TWr + TGap));

        write("busy3", 1'b0, 8'h30, 8'($urandom), 3, lat);

        write("stuck", 1'b0, 8'h40, 8'($urandom), 20, lat);
        write("after_timeout", 1'b0, 8'h40, 8'($urandom), 0, lat);

        for (int r = 0; r < 10; r++) begin
            write($sformatf("rand%0d", r), 1'($urandom), regs_pool[$urandom_range(0, 3)],
                  8'($urandom), int'($urandom_range(0, 5)), lat);
        end

        // Reset during the data strobe.
        bus.req_valid = 1'b1;
        bus.req_bank  = 1'b0;
        bus.req_reg   = 8'h55;
        bus.req_data  = 8'h3C;
        bus.data_i    = '0;
        found = 0;
        saw_done = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge MCLK);
            bus.req_valid = 1'b0;
            if (bus.done) saw_done = 1;
            if (bus.WR == 1'b0 && bus.address == 2'b01) begin
                found = 1;
                break;
            end
        end
        chk("ic_reached_data_strobe", 32'(found), 1);
        #2 IC = 1'b0;
        #1;
        chk("ic_strobes_released", 32'({bus.CS, bus.WR, bus.RD}), 32'b111);
        chk("ic_oe_released", 32'(bus.data_oe), 0);
        repeat (3) begin
            @(negedge MCLK);
            if (bus.done || bus.timeout) saw_done = 1;
        end
        IC = 1'b1;
        cache_valid = 1'b0;
        repeat (2) begin
            @(negedge MCLK);
            if (bus.done || bus.timeout) saw_done = 1;
        end
        chk("ic_no_pulse", 32'(saw_done), 0);
        write("after_ic", 1'b0, 8'h55, 8'h3C, 1, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
